uart_rx: RTL and testbench

Serial receiver for the UART datapath. It consumes the 16x-oversampling `tick` enable produced by the `baudrate` generator and deserializes an asynchronous `rx` line into parallel bytes. It delivers each byte with a one-cycle `rx_done` strobe, and flags stop-bit violations with `frame_err`. It sits beside the transmitter and shares the same `tick` source.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and frame defaults.
package uart_pkg;

   localparam int unsigned OVERSAMPLE  = 16;
   localparam int unsigned START_MID   = 7;
   localparam int unsigned DEF_DBIT    = 8;
   localparam int unsigned DEF_SB_TICK = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs, with a selectable reset level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop deserializer with framing-error detection.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = DEF_DBIT,
   parameter int unsigned SB_TICK = DEF_SB_TICK
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done,
   output logic            frame_err
);

   localparam logic [4:0] S_MID  = 5'(START_MID);
   localparam logic [4:0] S_LAST = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST = 3'(DBIT - 1);

   logic            rx_s;
   rx_state_t       state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [2:0]      n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx),
      .q  (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && !rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (tick) begin
               s_d = s_q + 5'd1;
               // Re-check the line at mid start bit to reject glitches.
               if (s_q == S_MID) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         DATA: begin
            if (tick) begin
               s_d = s_q + 5'd1;
               if (s_q == S_LAST) begin
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  s_d = '0;
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               s_d = s_q + 5'd1;
               if (s_q == S_STOP) begin
                  if (rx_s) begin
                     dout_d  = b_q;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
         end
         // Wait out a held-low line so it cannot look like a fresh start bit.
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout      = dout_q;
   assign rx_done   = done_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx: an 8N1 instance and a 7-bit, 2-stop-bit instance.
module tb_uart_rx;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx_drv = 1'b1;
   logic       line7 = 1'b0;
   logic       rx8, rx7;
   logic [7:0] dout8;
   logic [6:0] dout7;
   logic       done8, err8, done7, err7;

   assign rx8 = line7 ? 1'b1 : rx_drv;
   assign rx7 = line7 ? rx_drv : 1'b1;

   uart_rx dut8 (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .rx       (rx8),
      .dout     (dout8),
      .rx_done  (done8),
      .frame_err(err8)
   );

   uart_rx #(
      .DBIT   (7),
      .SB_TICK(32)
   ) dut7 (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .rx       (rx7),
      .dout     (dout7),
      .rx_done  (done7),
      .frame_err(err7)
   );

   always #10 clk = ~clk;

   int div_cnt = 0;
   int tick_count = 0;
   always @(posedge clk) begin
      if (div_cnt == TICK_DIV - 1) begin
         div_cnt <= 0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1;
         tick    <= 1'b0;
      end
      if (tick) tick_count <= tick_count + 1;
   end

   // Event recorder, sampled on the falling edge.
   int         done8_cnt = 0, err8_cnt = 0, done7_cnt = 0, err7_cnt = 0;
   int         t7_done = 0;
   logic [7:0] got8_q[$];
   int         t8_q[$];
   logic       both_high = 1'b0;
   always @(negedge clk) begin
      if (done8) begin
         done8_cnt <= done8_cnt + 1;
         got8_q.push_back(dout8);
         t8_q.push_back(tick_count);
      end
      if (err8) err8_cnt <= err8_cnt + 1;
      if (done7) begin
         done7_cnt <= done7_cnt + 1;
         t7_done   <= tick_count;
      end
      if (err7) err7_cnt <= err7_cnt + 1;
      if ((done8 && err8) || (done7 && err7)) both_high <= 1'b1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns just after the clock edge on which the DUT sees tick=1.
   task automatic wait_tick();
      @(negedge clk);
      while (!tick) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bits(input logic v, input int n);
      rx_drv = v;
      repeat (n) wait_tick();
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop,
                             input int stop_ticks);
      drive_bits(1'b0, 16);
      for (int i = 0; i < nbits; i++) drive_bits(data[i], 16);
      drive_bits(stop, stop_ticks);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_dout8;
      logic [7:0] exp_q[$];
      logic [7:0] c3;
      int         d0, e0, d7, e7, t0, lat;

      repeat (4) @(posedge clk);
      #1;
      check("reset_dout8", 32'(dout8), 32'h0);
      check("reset_done8", 32'(done8), 32'h0);
      check("reset_err8", 32'(err8), 32'h0);
      check("reset_dout7", 32'(dout7), 32'h0);
      rst = 1'b0;
      exp_dout8 = 8'h00;
      drive_bits(1'b1, 20);

      // Single 8N1 frame.
      got8_q.delete(); t8_q.delete();
      d0 = done8_cnt; e0 = err8_cnt;
      send_frame(8'hA5, 8, 1'b1, 16);
      drive_bits(1'b1, 4);
      exp_dout8 = 8'hA5;
      check("a5_done_count", 32'(done8_cnt - d0), 32'd1);
      check("a5_dout", 32'(got8_q[0]), 32'(exp_dout8));
      check("a5_no_err", 32'(err8_cnt - e0), 32'd0);

      // Back-to-back frames, no idle gap.
      got8_q.delete(); t8_q.delete();
      d0 = done8_cnt;
      send_frame(8'h00, 8, 1'b1, 16);
      send_frame(8'hFF, 8, 1'b1, 16);
      drive_bits(1'b1, 4);
      exp_dout8 = 8'hFF;
      check("b2b_done_count", 32'(done8_cnt - d0), 32'd2);
      check("b2b_first", 32'(got8_q[0]), 32'h00);
      check("b2b_second", 32'(got8_q[1]), 32'hFF);
      check("b2b_gap_ticks", 32'(t8_q[1] - t8_q[0]), 32'd160);
      check("b2b_no_err", 32'(err8_cnt - e0), 32'd0);

      // Short low glitch must be rejected.
      d0 = done8_cnt; e0 = err8_cnt;
      drive_bits(1'b0, 3);
      drive_bits(1'b1, 30);
      check("glitch_no_done", 32'(done8_cnt - d0), 32'd0);
      check("glitch_no_err", 32'(err8_cnt - e0), 32'd0);
      check("glitch_dout", 32'(dout8), 32'(exp_dout8));

      // Stop bit low, line held low long enough to retrigger if BREAK were skipped.
      d0 = done8_cnt; e0 = err8_cnt;
      send_frame(8'h3C, 8, 1'b0, 16);
      drive_bits(1'b0, 200);
      check("ferr_count", 32'(err8_cnt - e0), 32'd1);
      check("ferr_no_done", 32'(done8_cnt - d0), 32'd0);
      check("ferr_dout_kept", 32'(dout8), 32'(exp_dout8));
      drive_bits(1'b1, 20);
      send_frame(8'h55, 8, 1'b1, 16);
      drive_bits(1'b1, 4);
      exp_dout8 = 8'h55;
      check("after_break_done", 32'(done8_cnt - d0), 32'd1);
      check("after_break_dout", 32'(dout8), 32'(exp_dout8));
      check("after_break_err", 32'(err8_cnt - e0), 32'd1);

      // Reset in the middle of data bit 4.
      c3 = 8'hC3;
      drive_bits(1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bits(c3[i], 16);
      drive_bits(c3[4], 8);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_dout8 = 8'h00;
      check("midrst_dout", 32'(dout8), 32'(exp_dout8));
      check("midrst_done", 32'(done8), 32'h0);
      check("midrst_err", 32'(err8), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d0 = done8_cnt; e0 = err8_cnt;
      drive_bits(1'b1, 30);
      check("midrst_quiet", 32'((done8_cnt - d0) + (err8_cnt - e0)), 32'd0);
      send_frame(8'h81, 8, 1'b1, 16);
      drive_bits(1'b1, 4);
      exp_dout8 = 8'h81;
      check("post_rst_dout", 32'(dout8), 32'(exp_dout8));

      // 7 data bits, 2 stop bits on the second instance.
      line7 = 1'b1;
      drive_bits(1'b1, 4);
      d7 = done7_cnt; e7 = err7_cnt;
      t0 = tick_count;
      send_frame(8'h5A, 7, 1'b1, 32);
      drive_bits(1'b1, 4);
      lat = t7_done - t0;
      check("d7_done_count", 32'(done7_cnt - d7), 32'd1);
      check("d7_dout", 32'(dout7), 32'h5A);
      check("d7_no_err", 32'(err7_cnt - e7), 32'd0);
      check("d7_done_in_stop", 32'((lat >= 16 * 8) && (lat <= 16 * 8 + 32)), 32'd1);
      line7 = 1'b0;
      drive_bits(1'b1, 4);

      // Random bytes with random idle gaps (including none).
      got8_q.delete(); t8_q.delete();
      exp_q.delete();
      d0 = done8_cnt;
      for (int k = 0; k < 6; k++) begin
         logic [7:0] v;
         v = 8'($urandom);
         exp_q.push_back(v);
         send_frame(v, 8, 1'b1, 16);
         drive_bits(1'b1, int'($urandom_range(0, 5)));
      end
      drive_bits(1'b1, 4);
      check("rand_done_count", 32'(done8_cnt - d0), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("rand_byte%0d", k), 32'(got8_q[k]), 32'(exp_q[k]));
      end

      check("done_err_exclusive", 32'(both_high), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
